// File: rtl/axis_skid_pipeline.sv
// axis_skid_pipeline: a chain of DEPTH AXI-Stream register slices carrying
// tdata/tkeep/tuser/tlast as one payload.
// REG_MODE 2 uses skid slices, which register both the forward path and tready.
// REG_MODE 1 uses forward-only slices; tready stays combinational.
// REG_MODE 0 is pure wires.
// The occupancy output counts the beats currently held in the block.
module axis_skid_pipeline #(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 1,
  parameter int DEPTH       = 2,
  parameter int REG_MODE    = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [TDATA_WIDTH-1:0]           s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0]         s_axis_tkeep,
  input  logic [TUSER_WIDTH-1:0]           s_axis_tuser,
  input  logic                             s_axis_tlast,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic [TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0]         m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]           m_axis_tuser,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [$clog2(2*DEPTH+1)-1:0]     occupancy
);

  localparam int KEEP_W = TDATA_WIDTH / 8;
  localparam int PW     = TDATA_WIDTH + KEEP_W + TUSER_WIDTH + 1;
  localparam int OCC_W  = $clog2(2*DEPTH+1);

  if (DEPTH < 1 || TDATA_WIDTH % 8 != 0 || TUSER_WIDTH < 1 ||
      REG_MODE < 0 || REG_MODE > 2) begin : g_bad_params
    $fatal(1, "axis_skid_pipeline: illegal DEPTH, TDATA_WIDTH, TUSER_WIDTH or REG_MODE");
  end

  if (REG_MODE == 0) begin : g_bypass
    // Bypass mode holds nothing, so the clock and reset are intentionally unused.
    logic unused_ctrl;
    assign unused_ctrl   = clk ^ reset;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tvalid = s_axis_tvalid;
    assign s_axis_tready = m_axis_tready;
    assign occupancy     = '0;
  end else begin : g_pipe
    // Index i is the input of slice i; index DEPTH is the block output.
    logic [PW-1:0]    stage_data  [0:DEPTH];
    logic             stage_valid [0:DEPTH];
    logic             stage_ready [0:DEPTH];
    logic [OCC_W-1:0] occ_q;
    logic             beat_in;
    logic             beat_out;

    assign stage_data[0]      = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
    assign stage_valid[0]     = s_axis_tvalid;
    assign s_axis_tready      = stage_ready[0];
    assign stage_ready[DEPTH] = m_axis_tready;
    assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = stage_data[DEPTH];
    assign m_axis_tvalid      = stage_valid[DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_slice
      if (REG_MODE == 2) begin : g_skid
        logic [PW-1:0] main_data;
        logic [PW-1:0] skid_data;
        logic          main_v;
        logic          skid_v;
        logic          rdy;
        logic          accept;
        logic          main_open;

        assign accept    = stage_valid[i] & rdy;
        assign main_open = !main_v | stage_ready[i+1];

        // Slice state EMPTY/ONE/FULL; ready is registered as the inverse of the next skid_v.
        always_ff @(posedge clk) begin
          if (reset) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            rdy    <= 1'b0;
          end else if (main_open) begin
            // While skid_v is set, ready is low, so accept is 0 and the skid beat refills main.
            main_v <= skid_v | accept;
            skid_v <= 1'b0;
            rdy    <= 1'b1;
          end else begin
            skid_v <= skid_v | accept;
            rdy    <= !(skid_v | accept);
          end
        end

        // Payload moves with the valids; the skid copy is harmless while ready is high.
        always_ff @(posedge clk) begin
          if (main_open) main_data <= skid_v ? skid_data : stage_data[i];
          if (rdy)       skid_data <= stage_data[i];
        end

        assign stage_ready[i]   = rdy;
        assign stage_data[i+1]  = main_data;
        assign stage_valid[i+1] = main_v;
      end else begin : g_fwd
        logic [PW-1:0] main_data;
        logic          main_v;
        logic          rdy;

        assign rdy = !main_v | stage_ready[i+1];

        // A forward-only slice refills whenever it is empty or draining.
        always_ff @(posedge clk) begin
          if (reset)    main_v <= 1'b0;
          else if (rdy) main_v <= stage_valid[i];
        end

        // The payload register follows the valid register without reset.
        always_ff @(posedge clk) begin
          if (rdy) main_data <= stage_data[i];
        end

        assign stage_ready[i]   = rdy;
        assign stage_data[i+1]  = main_data;
        assign stage_valid[i+1] = main_v;
      end
    end

    assign beat_in  = s_axis_tvalid & stage_ready[0];
    assign beat_out = stage_valid[DEPTH] & m_axis_tready;

    // Beats enter only at the top and leave only at the bottom.
    // This count therefore equals the sum of all held valid bits.
    always_ff @(posedge clk) begin
      if (reset) occ_q <= '0;
      else       occ_q <= occ_q + OCC_W'(beat_in) - OCC_W'(beat_out);
    end

    assign occupancy = occ_q;
  end

endmodule

// File: tb/tb_axis_skid_pipeline.sv
// Directed bench for axis_skid_pipeline.
// Three instances are exercised: full skid (DEPTH 2), forward-only (DEPTH 3) and bypass.
module tb_axis_skid_pipeline;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Mode 2, DEPTH 2, TUSER 2
  logic [31:0] a_sd, a_md;
  logic [3:0]  a_sk, a_mk;
  logic [1:0]  a_su, a_mu;
  logic        a_sl, a_ml, a_sv, a_sr, a_mv, a_mr;
  logic [2:0]  a_occ;

  // Mode 1, DEPTH 3, TUSER 1
  logic [31:0] b_sd, b_md;
  logic [3:0]  b_sk, b_mk;
  logic [0:0]  b_su, b_mu;
  logic        b_sl, b_ml, b_sv, b_sr, b_mv, b_mr;
  logic [2:0]  b_occ;

  // Mode 0, DEPTH 2, TUSER 1
  logic [31:0] c_sd, c_md;
  logic [3:0]  c_sk, c_mk;
  logic [0:0]  c_su, c_mu;
  logic        c_sl, c_ml, c_sv, c_sr, c_mv, c_mr;
  logic [2:0]  c_occ;

  int n_tests = 0;
  int n_fail  = 0;

  axis_skid_pipeline #(.TDATA_WIDTH(32), .TUSER_WIDTH(2), .DEPTH(2), .REG_MODE(2)) u_m2 (
    .clk(clk), .reset(reset),
    .s_axis_tdata(a_sd), .s_axis_tkeep(a_sk), .s_axis_tuser(a_su), .s_axis_tlast(a_sl),
    .s_axis_tvalid(a_sv), .s_axis_tready(a_sr),
    .m_axis_tdata(a_md), .m_axis_tkeep(a_mk), .m_axis_tuser(a_mu), .m_axis_tlast(a_ml),
    .m_axis_tvalid(a_mv), .m_axis_tready(a_mr), .occupancy(a_occ));

  axis_skid_pipeline #(.TDATA_WIDTH(32), .TUSER_WIDTH(1), .DEPTH(3), .REG_MODE(1)) u_m1 (
    .clk(clk), .reset(reset),
    .s_axis_tdata(b_sd), .s_axis_tkeep(b_sk), .s_axis_tuser(b_su), .s_axis_tlast(b_sl),
    .s_axis_tvalid(b_sv), .s_axis_tready(b_sr),
    .m_axis_tdata(b_md), .m_axis_tkeep(b_mk), .m_axis_tuser(b_mu), .m_axis_tlast(b_ml),
    .m_axis_tvalid(b_mv), .m_axis_tready(b_mr), .occupancy(b_occ));

  axis_skid_pipeline #(.TDATA_WIDTH(32), .TUSER_WIDTH(1), .DEPTH(2), .REG_MODE(0)) u_m0 (
    .clk(clk), .reset(reset),
    .s_axis_tdata(c_sd), .s_axis_tkeep(c_sk), .s_axis_tuser(c_su), .s_axis_tlast(c_sl),
    .s_axis_tvalid(c_sv), .s_axis_tready(c_sr),
    .m_axis_tdata(c_md), .m_axis_tkeep(c_mk), .m_axis_tuser(c_mu), .m_axis_tlast(c_ml),
    .m_axis_tvalid(c_mv), .m_axis_tready(c_mr), .occupancy(c_occ));

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (a_mv !== 1'b0) begin n_fail++; $display("FAIL reset_m2_valid: got %b want 0", a_mv); end
    n_tests++; if (a_occ !== 3'd0) begin n_fail++; $display("FAIL reset_m2_occ: got %0d want 0", a_occ); end
    n_tests++; if (a_sr !== 1'b0) begin n_fail++; $display("FAIL reset_m2_ready: got %b want 0", a_sr); end
    n_tests++; if (b_mv !== 1'b0) begin n_fail++; $display("FAIL reset_m1_valid: got %b want 0", b_mv); end
    n_tests++; if (b_occ !== 3'd0) begin n_fail++; $display("FAIL reset_m1_occ: got %0d want 0", b_occ); end
    reset = 1'b0;
    #1;
    n_tests++; if (a_sr !== 1'b0) begin n_fail++; $display("FAIL reset_ready_before_edge: got %b want 0", a_sr); end
    @(posedge clk); #1;
    n_tests++; if (a_sr !== 1'b1) begin n_fail++; $display("FAIL reset_ready_rise: got %b want 1", a_sr); end
  endtask

  task automatic test_back_to_back();
    a_mr = 1'b1;
    for (int n = 0; n < 20; n++) begin
      logic        exp_v;
      logic [31:0] exp_d;
      logic        exp_l;
      exp_v = (n >= 2 && n <= 17);
      exp_d = exp_v ? 32'(n - 1) : 32'h0;
      exp_l = (n == 17);
      n_tests++;
      if (a_mv !== exp_v || (exp_v && (a_md !== exp_d || a_ml !== exp_l || a_mk !== 4'hF))) begin
        n_fail++;
        $display("FAIL b2b_out cyc %0d: got v=%b d=%h l=%b k=%h want v=%b d=%h l=%b k=f",
                 n, a_mv, a_md, a_ml, a_mk, exp_v, exp_d, exp_l);
      end
      n_tests++; if (a_sr !== 1'b1) begin n_fail++; $display("FAIL b2b_ready cyc %0d: got %b want 1", n, a_sr); end
      if (n < 16) begin
        a_sv = 1'b1; a_sd = 32'(n + 1); a_sl = (n == 15); a_sk = 4'hF; a_su = 2'b00;
      end else begin
        a_sv = 1'b0; a_sl = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int acc;
    acc = 0;
    a_mr = 1'b0; a_sk = 4'hF; a_su = 2'b01; a_sl = 1'b0;
    for (int c = 0; c < 10; c++) begin
      a_sv = 1'b1;
      a_sd = 32'h21 + 32'(acc);
      if (a_sr) acc++;
      @(posedge clk); #1;
    end
    a_sv = 1'b0;
    n_tests++; if (acc != 4) begin n_fail++; $display("FAIL bp_accepted: got %0d want 4", acc); end
    n_tests++; if (a_occ !== 3'd4) begin n_fail++; $display("FAIL bp_occ: got %0d want 4", a_occ); end
    n_tests++; if (a_sr !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b want 0", a_sr); end
    a_mr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (a_mv !== 1'b1 || a_md !== 32'h21 + 32'(k) || a_mu !== 2'b01) begin
        n_fail++;
        $display("FAIL bp_drain %0d: got v=%b d=%h u=%b want v=1 d=%h u=01", k, a_mv, a_md, a_mu, 32'h21 + 32'(k));
      end
      @(posedge clk); #1;
    end
    n_tests++; if (a_mv !== 1'b0) begin n_fail++; $display("FAIL bp_empty_valid: got %b want 0", a_mv); end
    n_tests++; if (a_occ !== 3'd0) begin n_fail++; $display("FAIL bp_empty_occ: got %0d want 0", a_occ); end
  endtask

  task automatic test_mid_reset();
    a_mr = 1'b0; a_sl = 1'b0;
    for (int c = 0; c < 3; c++) begin
      a_sv = 1'b1; a_sd = 32'h31 + 32'(c);
      @(posedge clk); #1;
    end
    n_tests++; if (a_occ !== 3'd3) begin n_fail++; $display("FAIL midrst_occ_before: got %0d want 3", a_occ); end
    // A beat offered in the same cycle as reset must be lost.
    a_sv = 1'b1; a_sd = 32'h34; a_sl = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (a_mv !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", a_mv); end
    n_tests++; if (a_occ !== 3'd0) begin n_fail++; $display("FAIL midrst_occ: got %0d want 0", a_occ); end
    n_tests++; if (a_sr !== 1'b0) begin n_fail++; $display("FAIL midrst_ready_low: got %b want 0", a_sr); end
    reset = 1'b0; a_sv = 1'b0; a_sl = 1'b0; a_mr = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (a_sr !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_rise: got %b want 1", a_sr); end
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (a_mv !== 1'b0) begin n_fail++; $display("FAIL midrst_no_emit %0d: got %b want 0", k, a_mv); end
      @(posedge clk); #1;
    end
    n_tests++; if (a_occ !== 3'd0) begin n_fail++; $display("FAIL midrst_occ_after: got %0d want 0", a_occ); end
  endtask

  task automatic test_random();
    logic [38:0] q[$];
    logic [38:0] exp;
    int acc, emit, sent, cycles;
    logic busy;
    acc = 0; emit = 0; sent = 0; cycles = 0; busy = 1'b0;
    a_sv = 1'b0;
    while (emit < 10000 && cycles < 45000) begin
      n_tests++;
      if (a_occ !== 3'(acc - emit)) begin
        n_fail++; $display("FAIL rand_occ cyc %0d: got %0d want %0d", cycles, a_occ, acc - emit);
      end
      if (!busy && sent < 10000 && $urandom_range(0, 1) == 1) begin
        a_sd = $urandom; a_sk = 4'($urandom); a_su = 2'($urandom);
        a_sl = ($urandom_range(0, 7) == 0); a_sv = 1'b1; busy = 1'b1; sent++;
      end else if (!busy) begin
        a_sv = 1'b0;
      end
      a_mr = ($urandom_range(0, 9) < 3);
      if (a_mv && a_mr) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_spurious cyc %0d: got beat %h want none", cycles, a_md);
        end else begin
          exp = q.pop_front();
          if ({a_ml, a_mu, a_mk, a_md} !== exp) begin
            n_fail++; $display("FAIL rand_data cyc %0d: got %h want %h", cycles, {a_ml, a_mu, a_mk, a_md}, exp);
          end
        end
        emit++;
      end
      if (a_sv && a_sr) begin
        q.push_back({a_sl, a_su, a_sk, a_sd});
        acc++;
        busy = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    a_sv = 1'b0; a_mr = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_tests++; if (acc != 10000 || emit != 10000) begin n_fail++; $display("FAIL rand_count: got acc=%0d emit=%0d want 10000/10000", acc, emit); end
    n_tests++; if (a_occ !== 3'd0 || a_mv !== 1'b0) begin n_fail++; $display("FAIL rand_final: got occ=%0d v=%b want 0/0", a_occ, a_mv); end
  endtask

  task automatic test_mode1_latency();
    b_mr = 1'b1; b_sk = 4'hF; b_su = 1'b0; b_sl = 1'b0;
    for (int n = 0; n < 10; n++) begin
      logic        exp_v;
      logic [31:0] exp_d;
      exp_v = (n >= 3 && n <= 8);
      exp_d = exp_v ? 32'h51 + 32'(n - 3) : 32'h0;
      n_tests++;
      if (b_mv !== exp_v || (exp_v && b_md !== exp_d)) begin
        n_fail++; $display("FAIL m1_latency cyc %0d: got v=%b d=%h want v=%b d=%h", n, b_mv, b_md, exp_v, exp_d);
      end
      if (n < 6) begin b_sv = 1'b1; b_sd = 32'h51 + 32'(n); end
      else b_sv = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mode1_full();
    int acc;
    acc = 0;
    b_mr = 1'b0;
    #1;
    for (int c = 0; c < 6; c++) begin
      b_sv = 1'b1; b_sd = 32'h61 + 32'(acc);
      if (b_sr) acc++;
      @(posedge clk); #1;
    end
    b_sv = 1'b0;
    n_tests++; if (acc != 3) begin n_fail++; $display("FAIL m1_accepted: got %0d want 3", acc); end
    n_tests++; if (b_occ !== 3'd3) begin n_fail++; $display("FAIL m1_occ: got %0d want 3", b_occ); end
    n_tests++; if (b_sr !== 1'b0) begin n_fail++; $display("FAIL m1_ready_full: got %b want 0", b_sr); end
    b_mr = 1'b1; #1;
    n_tests++; if (b_sr !== 1'b1) begin n_fail++; $display("FAIL m1_ready_track_hi: got %b want 1", b_sr); end
    b_mr = 1'b0; #1;
    n_tests++; if (b_sr !== 1'b0) begin n_fail++; $display("FAIL m1_ready_track_lo: got %b want 0", b_sr); end
    b_mr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (b_mv !== 1'b1 || b_md !== 32'h61 + 32'(k)) begin
        n_fail++; $display("FAIL m1_drain %0d: got v=%b d=%h want v=1 d=%h", k, b_mv, b_md, 32'h61 + 32'(k));
      end
      @(posedge clk); #1;
    end
    n_tests++; if (b_mv !== 1'b0 || b_occ !== 3'd0) begin n_fail++; $display("FAIL m1_empty: got v=%b occ=%0d want 0/0", b_mv, b_occ); end
  endtask

  task automatic test_bypass();
    logic [31:0] dv [0:3];
    logic [3:0]  kv [0:3];
    logic [3:0]  flags [0:3];
    dv[0] = 32'hDEADBEEF; kv[0] = 4'hF; flags[0] = 4'b1011;
    dv[1] = 32'h00000000; kv[1] = 4'h1; flags[1] = 4'b0100;
    dv[2] = 32'hFFFFFFFF; kv[2] = 4'h8; flags[2] = 4'b1110;
    dv[3] = 32'h12345678; kv[3] = 4'h6; flags[3] = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      c_sd = dv[k]; c_sk = kv[k];
      c_sl = flags[k][3]; c_su = flags[k][2]; c_sv = flags[k][1]; c_mr = flags[k][0];
      #1;
      n_tests++;
      if (c_md !== dv[k] || c_mk !== kv[k] || c_ml !== flags[k][3] || c_mu !== flags[k][2] ||
          c_mv !== flags[k][1]) begin
        n_fail++;
        $display("FAIL bypass_fwd %0d: got d=%h k=%h l=%b u=%b v=%b want d=%h k=%h l=%b u=%b v=%b",
                 k, c_md, c_mk, c_ml, c_mu, c_mv, dv[k], kv[k], flags[k][3], flags[k][2], flags[k][1]);
      end
      n_tests++; if (c_sr !== flags[k][0]) begin n_fail++; $display("FAIL bypass_ready %0d: got %b want %b", k, c_sr, flags[k][0]); end
      n_tests++; if (c_occ !== 3'd0) begin n_fail++; $display("FAIL bypass_occ %0d: got %0d want 0", k, c_occ); end
    end
  endtask

  initial begin
    reset = 1'b1;
    a_sd = '0; a_sk = '0; a_su = '0; a_sl = 1'b0; a_sv = 1'b0; a_mr = 1'b0;
    b_sd = '0; b_sk = '0; b_su = '0; b_sl = 1'b0; b_sv = 1'b0; b_mr = 1'b0;
    c_sd = '0; c_sk = '0; c_su = '0; c_sl = 1'b0; c_sv = 1'b0; c_mr = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_random();
    test_mode1_latency();
    test_mode1_full();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
